// File: rtl/zap_fetch_queue.sv
// zap_fetch_queue: fetch-to-decode FIFO that stops accepting words after an instruction abort until flushed.
module zap_fetch_queue #(
   parameter int          DEPTH         = 4,
   parameter logic [31:0] ABORT_PAYLOAD = 32'd0
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_clear,
   input  logic                     i_stall,
   input  logic                     i_valid,
   input  logic [31:0]              i_instruction,
   input  logic                     i_instr_abort,
   input  logic [31:0]              i_pc_ff,
   input  logic                     i_cpsr_ff_t,
   input  logic [1:0]               i_taken,
   output logic                     o_ready,
   output logic                     o_valid,
   output logic [31:0]              o_instruction,
   output logic                     o_instr_abort,
   output logic [31:0]              o_pc_ff,
   output logic [31:0]              o_pc_plus_8_ff,
   output logic [1:0]               o_taken_ff,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   mem_instr [DEPTH];
   logic          mem_abort [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_pc8   [DEPTH];
   logic [1:0]    mem_taken [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   level;
   logic          sleep, push, pop;
   // Ready is held low while reset is asserted so no word is lost across the reset edge.
   assign o_ready        = i_reset_n && !sleep && (level != (AW+1)'(DEPTH));
   assign o_valid        = level != '0;
   assign o_level        = level;
   assign push           = i_valid && o_ready && !i_clear;
   assign pop            = o_valid && !i_stall && !i_clear;
   assign o_instruction  = mem_instr[rd_ptr];
   assign o_instr_abort  = o_valid && mem_abort[rd_ptr];
   assign o_pc_ff        = mem_pc[rd_ptr];
   assign o_pc_plus_8_ff = mem_pc8[rd_ptr];
   assign o_taken_ff     = mem_taken[rd_ptr];
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         sleep  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (push && i_instr_abort) sleep <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= i_instr_abort ? ABORT_PAYLOAD : i_instruction;
         mem_abort[wr_ptr] <= i_instr_abort;
         mem_pc[wr_ptr]    <= i_pc_ff;
         mem_pc8[wr_ptr]   <= i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
         mem_taken[wr_ptr] <= i_taken;
      end
   end
endmodule

// File: tb/tb_zap_fetch_queue.sv
// tb_zap_fetch_queue: directed and random checks of zap_fetch_queue against a queue-based model.
module tb_zap_fetch_queue;
   localparam int DEPTH = 4;
   logic        i_clk = 0, i_reset_n = 0, i_clear = 0, i_stall = 0, i_valid = 0;
   logic [31:0] i_instruction = 0, i_pc_ff = 0;
   logic        i_instr_abort = 0, i_cpsr_ff_t = 0;
   logic [1:0]  i_taken = 0;
   logic        o_ready, o_valid, o_instr_abort;
   logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
   logic [1:0]  o_taken_ff;
   logic [2:0]  o_level;

   zap_fetch_queue #(.DEPTH(DEPTH), .ABORT_PAYLOAD(32'd0)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(i_clear), .i_stall(i_stall),
      .i_valid(i_valid), .i_instruction(i_instruction), .i_instr_abort(i_instr_abort),
      .i_pc_ff(i_pc_ff), .i_cpsr_ff_t(i_cpsr_ff_t), .i_taken(i_taken),
      .o_ready(o_ready), .o_valid(o_valid), .o_instruction(o_instruction),
      .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff),
      .o_taken_ff(o_taken_ff), .o_level(o_level));

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] instr;
      logic        abort;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic [1:0]  taken;
   } entry_t;

   entry_t q[$];
   bit     m_sleep = 0;
   int     total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rn, input logic clr, input logic stl, input logic vld,
                      input logic ab, input logic t, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [1:0] tk);
      bit     exp_ready, do_push, do_pop;
      entry_t e;
      i_reset_n = rn; i_clear = clr; i_stall = stl; i_valid = vld;
      i_instr_abort = ab; i_cpsr_ff_t = t; i_instruction = ins; i_pc_ff = pc; i_taken = tk;
      #1;
      exp_ready = rn && !m_sleep && q.size() < DEPTH;
      chk("ready", {31'd0, o_ready}, {31'd0, exp_ready});
      do_push = vld && exp_ready && !clr;
      do_pop  = q.size() != 0 && !stl && !clr;
      @(posedge i_clk);
      if (!rn || clr) begin
         q.delete();
         m_sleep = 0;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.instr = ab ? 32'd0 : ins;
            e.abort = ab;
            e.pc    = pc;
            e.pc8   = pc + (t ? 32'd4 : 32'd8);
            e.taken = tk;
            q.push_back(e);
            if (ab) m_sleep = 1;
         end
      end
      #1;
      chk("level", {29'd0, o_level}, q.size());
      chk("valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("instr", o_instruction, q[0].instr);
         chk("abort", {31'd0, o_instr_abort}, {31'd0, q[0].abort});
         chk("pc", o_pc_ff, q[0].pc);
         chk("pc8", o_pc_plus_8_ff, q[0].pc8);
         chk("taken", {30'd0, o_taken_ff}, {30'd0, q[0].taken});
      end
   endtask

   task automatic idle(input logic stl);
      cyc(1, 0, stl, 0, 0, 0, 32'd0, 32'd0, 2'd0);
   endtask

   initial begin
      @(posedge i_clk); #1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 32'h1234, 32'h40, 0);
      chk("rst_abort", {31'd0, o_instr_abort}, 32'd0);
      // fill with stall held
      for (int i = 0; i < 5; i++)
         cyc(1, 0, 1, 1, 0, 0, $urandom, 32'(4 * i), 2'($urandom));
      chk("fill_level", {29'd0, o_level}, 32'd4);
      chk("fill_head", o_pc_ff, 32'h0);
      chk("fill_ready", {31'd0, o_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) chk("drain_pc8_0", o_pc_plus_8_ff, 32'h8);
         idle(0);
      end
      chk("drain_empty", {31'd0, o_valid}, 32'd0);
      // abort stops intake until clear
      cyc(1, 0, 1, 1, 0, 0, 32'hE3A00001, 32'h100, 2'd1);
      cyc(1, 0, 1, 1, 1, 0, 32'hE1A00000, 32'h104, 2'd2);
      idle(0);
      chk("abort_instr", o_instruction, 32'h0);
      chk("abort_flag", {31'd0, o_instr_abort}, 32'd1);
      chk("abort_pc", o_pc_ff, 32'h104);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 0, $urandom, 32'h200 + 32'(4 * i), 0);
      chk("sleep_ready", {31'd0, o_ready}, 32'd0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("wake_ready", {31'd0, o_ready}, 32'd1);
      // clear beats a same-cycle push
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 0, $urandom, 32'h300 + 32'(4 * i), 0);
      cyc(1, 1, 0, 1, 0, 0, 32'hDEAD, 32'h400, 0);
      chk("clr_level", {29'd0, o_level}, 32'd0);
      // thumb increment wraps the address space
      cyc(1, 0, 1, 1, 0, 1, 32'h4770, 32'hFFFFFFFE, 2'd3);
      chk("thumb_pc8", o_pc_plus_8_ff, 32'h00000002);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 0, i[0], $urandom, 32'h500 + 32'(4 * i), 2'($urandom));
      chk("pair_level", {29'd0, o_level}, 32'd1);
      // reset while sleeping with two entries
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 32'h11, 32'h600, 0);
      cyc(1, 0, 1, 1, 1, 0, 32'h22, 32'h604, 0);
      cyc(0, 0, 1, 1, 0, 0, 32'h33, 32'h608, 0);
      chk("rst_level", {29'd0, o_level}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      idle(0);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 25) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'($urandom),
             $urandom, $urandom, 2'($urandom));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/zap_fetch_queue.md
ZAP_FETCH_QUEUE -- requirements
Module: zap_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter ABORT_PAYLOAD, default 32'd0, instruction word substituted on an instruction abort.
REQ-003 SHALL have port i_clk  input  1  core clock; all state changes on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_clear  input  1  flush queue (branch/writeback/decode redirect, OR-ed upstream).
REQ-006 SHALL have port i_stall  input  1  downstream cannot accept head entry this cycle.
REQ-007 SHALL have port i_valid  input  1  I-cache word valid.
REQ-008 SHALL have port i_instruction  input  32  instruction word.
REQ-009 SHALL have port i_instr_abort  input  1  instruction abort for this word; meaningful only with i_valid.
REQ-010 SHALL have port i_pc_ff  input  32  address of the incoming word.
REQ-011 SHALL have port i_cpsr_ff_t  input  1  CPSR T bit at fetch time.
REQ-012 SHALL have port i_taken  input  2  branch predictor state for the incoming word.
REQ-013 SHALL have port o_ready  output  1  queue accepts a word this cycle.
REQ-014 SHALL have port o_valid  output  1  head entry valid.
REQ-015 SHALL have ports o_instruction (32), o_instr_abort (1), o_pc_ff (32), o_pc_plus_8_ff (32), o_taken_ff (2), all outputs, head entry fields.
REQ-016 SHALL have port o_level  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-017 SHALL accept (push) a word when i_valid && o_ready && !i_clear.
REQ-018 SHALL pop the head when o_valid && !i_stall && !i_clear.
REQ-019 o_ready SHALL be !sleep && (o_level != DEPTH); combinational from registered state only; no push on full even if a pop occurs the same cycle.
REQ-020 Outputs SHALL be driven from registered storage; a word pushed in cycle N SHALL be visible at o_* in cycle N+1 if the queue was empty.
REQ-021 o_valid SHALL equal (o_level != 0).
REQ-022 Simultaneous push and pop SHALL leave o_level unchanged and preserve FIFO order.
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 At push, o_pc_plus_8_ff field SHALL be i_pc_ff + 4 if i_cpsr_ff_t else i_pc_ff + 8, modulo 2^32.
REQ-025 At push with i_instr_abort=1, stored instruction SHALL be ABORT_PAYLOAD, abort flag 1, and sleep SHALL set.
REQ-026 While sleep=1, no push SHALL occur; entries already queued (including the abort entry) SHALL drain normally.
REQ-027 Sleep SHALL clear only on i_clear or reset.
REQ-028 i_clear SHALL, in one cycle, set o_level=0, both pointers=0, sleep=0; takes priority over push, pop and stall.
REQ-029 While i_stall=1, head entry and all o_* fields SHALL hold stable.
REQ-030 Storage contents SHALL be unchanged except by push; entries beyond o_level are don't-care.

Reset
REQ-031 When i_reset_n=0 at a clock edge: o_level=0, pointers=0, sleep=0, o_valid=0, o_instr_abort=0, o_ready=0 during reset cycle, 1 the cycle after.
REQ-032 Reset SHALL override i_clear, push and pop, including mid-drain and while sleeping.
REQ-033 Data fields (instruction, PC, taken) need not be reset.

Verification
REQ-034 Fill: DEPTH=4, i_stall=1, push 5 words PC 0x0,4,8,C,10 -> o_ready=0 after 4th, o_level=4, 5th not accepted, head PC 0x0.
REQ-035 Drain order: after REQ-034 release i_stall -> o_pc_ff 0x0,4,8,C on consecutive cycles, o_pc_plus_8_ff 0x8,C,10,14, then o_valid=0.
REQ-036 Abort: push PC 0x100 normal then PC 0x104 abort with i_instruction=0xE1A00000 -> 0x104 entry shows o_instruction=0x0, o_instr_abort=1; o_ready stays 0 until i_clear.
REQ-037 Clear: level 3, i_clear=1 with i_valid=1 same cycle -> next cycle o_level=0, o_valid=0, pushed word discarded.
REQ-038 Thumb and wrap: i_cpsr_ff_t=1, PC 0xFFFFFFFE -> o_pc_plus_8_ff=0x00000002; 10 push/pop pairs at level 1 -> level stays 1, order preserved.
REQ-039 Reset mid-operation: level 2, sleep=1, i_reset_n=0 one cycle -> o_level=0, o_valid=0, o_ready=1 next cycle.
